// File: rtl/data_mem_responder.sv
// ============================================================================
// Module   : data_mem_responder
// Purpose  : Multi-cycle data memory that serves MEM-stage loads and stores
//            with a fixed access latency, a ready/err pulse and a stall.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] writeData,
  output logic [31:0] ReadData,
  output logic        ready,
  output logic        err,
  output logic        stall
);

  localparam int         c_IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [1:0] c_IDLE      = 2'd0;
  localparam logic [1:0] c_WAIT      = 2'd1;
  localparam logic [1:0] c_DONE      = 2'd2;
  localparam logic [31:0] c_DEPTH    = 32'(DEPTH_WORDS);
  localparam bit         c_SINGLE    = (LATENCY == 1);
  localparam logic [3:0] c_WAIT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  logic [1:0]         r_state;
  logic [1:0]         w_nextState;
  logic [3:0]         r_count;
  logic               r_reqRead;
  logic               r_reqWrite;
  logic               r_reqErr;
  logic [c_IDX_W-1:0] r_reqIdx;
  logic [31:0]        r_reqData;
  logic [31:0]        r_readData;
  logic               r_ready;
  logic               r_err;
  logic [31:0]        r_mem [DEPTH_WORDS];

  logic               w_req;
  logic               w_accept;
  logic               w_inErr;
  logic               w_enterDone;
  logic               w_cRead;
  logic               w_cWrite;
  logic               w_cErr;
  logic [c_IDX_W-1:0] w_cIdx;
  logic [31:0]        w_cData;
  logic               w_memWe;

  assign w_req    = MemRead | MemWrite;
  assign w_accept = (r_state == c_IDLE) && w_req;
  assign w_inErr  = (Address[1:0] != 2'b00) ||
                    ({2'b00, Address[31:2]} >= c_DEPTH) ||
                    (MemRead && MemWrite);

  assign w_enterDone = (w_accept && c_SINGLE) ||
                       ((r_state == c_WAIT) && (r_count == 4'd0));

  // With single-cycle latency the commit edge is also the acceptance edge,
  // so the live inputs stand in for the not-yet-latched request.
  assign w_cRead  = (r_state == c_IDLE) ? MemRead   : r_reqRead;
  assign w_cWrite = (r_state == c_IDLE) ? MemWrite  : r_reqWrite;
  assign w_cErr   = (r_state == c_IDLE) ? w_inErr   : r_reqErr;
  assign w_cIdx   = (r_state == c_IDLE) ? Address[c_IDX_W+1:2] : r_reqIdx;
  assign w_cData  = (r_state == c_IDLE) ? writeData : r_reqData;
  assign w_memWe  = w_enterDone && rst && w_cWrite && !w_cErr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_req) begin
          w_nextState = c_SINGLE ? c_DONE : c_WAIT;
        end
      end
      c_WAIT: begin
        if (r_count == 4'd0) begin
          w_nextState = c_DONE;
        end
      end
      c_DONE:  w_nextState = c_IDLE;
      default: w_nextState = c_IDLE;
    endcase
  end

  always_comb begin
    stall = w_accept || (r_state == c_WAIT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count    <= 4'd0;
      r_reqRead  <= 1'b0;
      r_reqWrite <= 1'b0;
      r_reqErr   <= 1'b0;
      r_reqIdx   <= '0;
      r_reqData  <= 32'd0;
      r_readData <= 32'd0;
      r_ready    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_reqRead  <= MemRead;
        r_reqWrite <= MemWrite;
        r_reqErr   <= w_inErr;
        r_reqIdx   <= Address[c_IDX_W+1:2];
        r_reqData  <= writeData;
        r_count    <= c_WAIT_INIT;
      end else if ((r_state == c_WAIT) && (r_count != 4'd0)) begin
        r_count <= r_count - 4'd1;
      end
      r_ready <= w_enterDone;
      r_err   <= w_enterDone && w_cErr;
      if (w_enterDone) begin
        if (w_cErr) begin
          r_readData <= 32'd0;
        end else if (w_cRead) begin
          r_readData <= r_mem[w_cIdx];
        end
      end
    end
  end

  // Array contents survive reset; the write enable is qualified by rst so an
  // access interrupted on its commit edge leaves memory untouched.
  always_ff @(posedge clk) begin
    if (w_memWe) begin
      r_mem[w_cIdx] <= w_cData;
    end
  end

  assign ReadData = r_readData;
  assign ready    = r_ready;
  assign err      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
// Module   : tb_data_mem_responder
// Purpose  : Self-checking bench for data_mem_responder at latencies 3, 1, 15.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_data_mem_responder;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] Address = 32'd0;
  logic [31:0] writeData = 32'd0;

  logic [31:0] rdV [3];
  logic        readyV [3];
  logic        errV [3];
  logic        stallV [3];

  int checks = 0;
  int errors = 0;
  int sel = 0;
  int latV [3] = '{3, 1, 15};

  logic [31:0] memM [int];
  logic [31:0] rdModel = 32'd0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .writeData(writeData),
    .ReadData(rdV[0]), .ready(readyV[0]), .err(errV[0]), .stall(stallV[0]));

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .writeData(writeData),
    .ReadData(rdV[1]), .ready(readyV[1]), .err(errV[1]), .stall(stallV[1]));

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(15)) dut15 (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .writeData(writeData),
    .ReadData(rdV[2]), .ready(readyV[2]), .err(errV[2]), .stall(stallV[2]));

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access against the selected instance; expectations come from memM.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input bit chg,
                        input logic [31:0] addr2, input logic [31:0] data2,
                        input string tag);
    int          cyc = 0;
    int          stallCnt = 0;
    int          readyCyc = -1;
    int          key;
    logic        expErr;
    logic [31:0] expRd;
    bit          known = 1'b1;
    key    = int'(addr >> 2);
    expErr = (addr % 4 != 0) || ((addr >> 2) >= DEPTH) || (rd && wr);
    expRd  = rdModel;
    if (expErr) begin
      expRd = 32'd0;
    end else if (rd) begin
      if (memM.exists(key)) expRd = memM[key];
      else known = 1'b0;
    end else begin
      memM[key] = data;
      if (sel != 0) known = 1'b0;
    end
    if (sel == 0 && known) rdModel = expRd;

    @(negedge clk);
    MemRead = rd; MemWrite = wr; Address = addr; writeData = data;
    while (cyc < 40) begin
      #1;
      if (readyV[sel]) begin
        readyCyc = cyc;
        break;
      end
      if (stallV[sel]) stallCnt++;
      @(negedge clk);
      cyc++;
      if (chg && cyc == 1) begin
        Address = addr2; writeData = data2;
      end
    end
    check(32'(readyCyc), 32'(latV[sel]), {tag, "_readyCycle"});
    check(32'(stallCnt), 32'(latV[sel]), {tag, "_stallCycles"});
    check({31'd0, stallV[sel]}, 32'd0, {tag, "_stallAtReady"});
    check({31'd0, errV[sel]}, {31'd0, expErr}, {tag, "_err"});
    if (known) check(rdV[sel], expRd, {tag, "_ReadData"});
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  initial begin
    int          cyc;
    int          got;
    bit          sawReady;
    logic [31:0] a;
    logic [31:0] d;
    int          op;

    repeat (2) @(negedge clk);
    #1;
    check(rdV[0], 32'd0, "reset_ReadData");
    check({31'd0, readyV[0]}, 32'd0, "reset_ready");
    check({31'd0, errV[0]}, 32'd0, "reset_err");
    check({31'd0, stallV[0]}, 32'd0, "reset_stall");
    @(negedge clk);
    rst = 1'b1;

    for (int w = 0; w < 16; w++) begin
      d = (w < 3) ? 32'(w + 1) : $urandom;
      access(1'b0, 1'b1, 32'(w * 4), d, 1'b0, 32'd0, 32'd0, "preload");
    end

    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'd0, 32'd0, "store10");
    access(1'b1, 1'b0, 32'h10, 32'd0,        1'b0, 32'd0, 32'd0, "load10");
    access(1'b1, 1'b0, 32'h2,  32'd0,        1'b0, 32'd0, 32'd0, "loadMisaligned");
    access(1'b0, 1'b1, 32'(DEPTH * 4), 32'h12345678, 1'b0, 32'd0, 32'd0, "storeOutOfRange");
    access(1'b1, 1'b0, 32'h0,  32'd0,        1'b0, 32'd0, 32'd0, "loadWord0");
    access(1'b1, 1'b1, 32'h8,  32'h55,       1'b0, 32'd0, 32'd0, "readWriteBoth");
    access(1'b1, 1'b0, 32'h8,  32'd0,        1'b0, 32'd0, 32'd0, "loadWord2");

    // Back-to-back loads with the request held across accesses.
    @(negedge clk);
    MemRead = 1'b1; Address = 32'h0;
    cyc = 0; got = 0;
    while (cyc < 40 && got < 3) begin
      #1;
      if (readyV[0]) begin
        check(32'(cyc), 32'(3 + 4 * got), "b2b_readyCycle");
        check(rdV[0], 32'(got + 1), "b2b_ReadData");
        got++;
        Address = 32'(got * 4);
        if (got == 3) MemRead = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    MemRead = 1'b0;
    check(32'(got), 32'd3, "b2b_count");
    rdModel = 32'd3;

    access(1'b0, 1'b1, 32'h20, 32'h11111111, 1'b1, 32'h24, 32'h22222222, "storeMidChange");
    access(1'b1, 1'b0, 32'h20, 32'd0, 1'b0, 32'd0, 32'd0, "load20");
    access(1'b1, 1'b0, 32'h24, 32'd0, 1'b0, 32'd0, 32'd0, "load24");

    // Reset pulled during the first wait cycle of a store.
    @(negedge clk);
    MemWrite = 1'b1; Address = 32'h30; writeData = 32'hAAAAAAAA;
    @(negedge clk);
    rst = 1'b0; MemWrite = 1'b0;
    #1;
    check({31'd0, stallV[0]}, 32'd0, "rstMid_stall");
    check({31'd0, readyV[0]}, 32'd0, "rstMid_ready");
    check(rdV[0], 32'd0, "rstMid_ReadData");
    sawReady = 1'b0;
    repeat (4) begin
      @(negedge clk);
      #1;
      if (readyV[0]) sawReady = 1'b1;
    end
    check({31'd0, sawReady}, 32'd0, "rstMid_noReady");
    @(negedge clk);
    rst = 1'b1;
    rdModel = 32'd0;
    access(1'b1, 1'b0, 32'h30, 32'd0, 1'b0, 32'd0, 32'd0, "load30AfterReset");

    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 9));
      a  = 32'($urandom_range(0, 15)) * 32'd4;
      d  = $urandom;
      if (op <= 3)      access(1'b1, 1'b0, a, d, 1'b0, 32'd0, 32'd0, "rndLoad");
      else if (op <= 7) access(1'b0, 1'b1, a, d, 1'b0, 32'd0, 32'd0, "rndStore");
      else if (op == 8) access(1'b1, 1'b1, a, d, 1'b0, 32'd0, 32'd0, "rndBoth");
      else if ($urandom_range(0, 1) == 0)
        access(1'b1, 1'b0, a + 32'($urandom_range(1, 3)), d, 1'b0, 32'd0, 32'd0, "rndMisaligned");
      else
        access(1'b0, 1'b1, 32'(DEPTH + int'($urandom_range(0, 1000))) * 32'd4, d,
               1'b0, 32'd0, 32'd0, "rndOutOfRange");
    end

    // Latency extremes on the other two instances.
    repeat (20) @(negedge clk);
    sel = 2;
    access(1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 1'b0, 32'd0, 32'd0, "lat15_store");
    repeat (20) @(negedge clk);
    sel = 1;
    access(1'b1, 1'b0, 32'h40, 32'd0, 1'b0, 32'd0, 32'd0, "lat1_load");
    repeat (20) @(negedge clk);
    sel = 2;
    access(1'b1, 1'b0, 32'h40, 32'd0, 1'b0, 32'd0, 32'd0, "lat15_load");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
